// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with shadowed divide ratios.
// Define CLKDIV_DUTY_EN to make the clk_div high time programmable through cfg_high.
module clk_div_gen #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DIV_INIT = 4,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             inclk0,
    input  logic             areset_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  ce,
    output logic [N_CH-1:0]  clk_div
);

    localparam logic [CNT_W-1:0] DivInit  = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] HighInit = CNT_W'(DIV_INIT / 2);
    localparam logic [CNT_W-1:0] One      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q      [N_CH];
    logic [CNT_W-1:0] cnt_d      [N_CH];
    logic [CNT_W-1:0] div_act_q  [N_CH];
    logic [CNT_W-1:0] div_act_d  [N_CH];
    logic [CNT_W-1:0] div_pend_q [N_CH];
    logic [CNT_W-1:0] div_pend_d [N_CH];
    logic [CNT_W-1:0] high_eff   [N_CH];
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] high_act_q  [N_CH];
    logic [CNT_W-1:0] high_act_d  [N_CH];
    logic [CNT_W-1:0] high_pend_q [N_CH];
    logic [CNT_W-1:0] high_pend_d [N_CH];
`else
    logic unused_cfg_high;
    assign unused_cfg_high = ^cfg_high;
`endif

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ce_q, ce_d;
    logic [N_CH-1:0] clk_div_q, clk_div_d;
    logic [N_CH-1:0] run_q;
    logic [N_CH-1:0] wrap, apply, wr_hit;
    logic            cfg_ok;
    logic            cfg_err_q;

    always_comb begin
        cfg_ok = cfg_wr && (cfg_div != '0) && (32'(cfg_ch) < N_CH);
`ifdef CLKDIV_DUTY_EN
        cfg_ok = cfg_ok && (cfg_high < cfg_div);
`endif
        for (int i = 0; i < N_CH; i++) begin
            // run_q marks the first enabled edge, which only loads cnt=0
            wrap[i]   = en[i] && run_q[i] && (cnt_q[i] == div_act_q[i] - One);
            apply[i]  = pending_q[i] && (wrap[i] || !en[i] || sync);
            wr_hit[i] = cfg_ok && (cfg_ch == CH_W'(i));

            div_act_d[i]  = apply[i] ? div_pend_q[i] : div_act_q[i];
            div_pend_d[i] = wr_hit[i] ? cfg_div : div_pend_q[i];
`ifdef CLKDIV_DUTY_EN
            high_act_d[i]  = apply[i] ? high_pend_q[i] : high_act_q[i];
            high_pend_d[i] = wr_hit[i] ? cfg_high : high_pend_q[i];
            high_eff[i]    = high_act_d[i];
`else
            high_eff[i]    = div_act_d[i] >> 1;
`endif
            // A new write on an applying edge stays pending for the next period
            pending_d[i] = wr_hit[i] || (pending_q[i] && !apply[i]);

            cnt_d[i] = (en[i] && run_q[i] && !sync && !wrap[i]) ? cnt_q[i] + One : '0;

            // Outputs are registered from next-state values so they align with cnt
            ce_d[i]      = en[i] && !sync && (cnt_d[i] == div_act_d[i] - One);
            clk_div_d[i] = en[i] && (cnt_d[i] < high_eff[i]);
        end
    end

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]       <= '0;
                div_act_q[i]   <= DivInit;
                div_pend_q[i]  <= DivInit;
`ifdef CLKDIV_DUTY_EN
                high_act_q[i]  <= HighInit;
                high_pend_q[i] <= HighInit;
`endif
            end
            pending_q <= '0;
            ce_q      <= '0;
            clk_div_q <= '0;
            run_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]       <= cnt_d[i];
                div_act_q[i]   <= div_act_d[i];
                div_pend_q[i]  <= div_pend_d[i];
`ifdef CLKDIV_DUTY_EN
                high_act_q[i]  <= high_act_d[i];
                high_pend_q[i] <= high_pend_d[i];
`endif
            end
            pending_q <= pending_d;
            ce_q      <= ce_d;
            clk_div_q <= clk_div_d;
            run_q     <= en;
            cfg_err_q <= cfg_wr && !cfg_ok;
        end
    end

`ifndef CLKDIV_DUTY_EN
    logic unused_high_init;
    assign unused_high_init = ^HighInit;
`endif

    assign cfg_err = cfg_err_q;
    assign pending = pending_q;
    assign ce      = ce_q;
    assign clk_div = clk_div_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen, three channels so that cfg_ch=3 is out of range.
// Covers the CLKDIV_DUTY_EN variant when the macro is defined for the build.
module tb_clk_div_gen;

    logic       inclk0;
    logic       areset_n;
    logic [2:0] en;
    logic       sync;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_high;
    logic       cfg_err;
    logic [2:0] pending;
    logic [2:0] ce;
    logic [2:0] clk_div;

    int n_checks;
    int n_errors;

    clk_div_gen #(
        .N_CH    (3),
        .CNT_W   (8),
        .DIV_INIT(4)
    ) dut (
        .inclk0  (inclk0),
        .areset_n(areset_n),
        .en      (en),
        .sync    (sync),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_high(cfg_high),
        .cfg_err (cfg_err),
        .pending (pending),
        .ce      (ce),
        .clk_div (clk_div)
    );

    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge inclk0);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] div, input logic [7:0] high);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = div;
        cfg_high = high;
    endtask

    // Channel 0 at the reset ratio of 4, starting on the first edge after release
    task automatic run_s1(input string tag);
        logic e_ce, e_clk;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_ce  = (k % 4 == 0);
            e_clk = ((k - 1) % 4 < 2);
            check({tag, " ce"}, ce, {2'b00, e_ce});
            check({tag, " clk_div"}, clk_div, {2'b00, e_clk});
        end
    endtask

    initial begin
        logic e0, e1, e2, c0, c1;
        int   c;
        n_checks = 0;
        n_errors = 0;
        areset_n = 1'b1;
        en       = 3'b001;
        sync     = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
        #1 areset_n = 1'b0;
        #11;
        check("rst ce", ce, 3'b000);
        check("rst clk_div", clk_div, 3'b000);
        check("rst pending", pending, 3'b000);
        check("rst cfg_err", cfg_err, 1'b0);
        areset_n = 1'b1;

        // 1: default ratio
        run_s1("s1");

        // 2: ratio change on channel 1 takes effect at the wrap
        en = 3'b010;
        step();
        check("s2 start ce", ce, 3'b000);
        check("s2 start clk", clk_div, 3'b010);
        step();
        check("s2 cnt1 clk", clk_div, 3'b010);
        wr(2'd1, 8'd5, 8'd2);
        step();
        cfg_wr = 1'b0;
        check("s2 pend set", pending, 3'b010);
        check("s2 cnt2 clk", clk_div, 3'b000);
        step();
        check("s2 old ce", ce, 3'b010);
        check("s2 pend held", pending, 3'b010);
        step();
        check("s2 pend clr", pending, 3'b000);
        check("s2 wrap ce", ce, 3'b000);
        check("s2 wrap clk", clk_div, 3'b010);
        for (int k = 1; k <= 10; k++) begin
            step();
            c  = k % 5;
            e1 = (c == 4);
            c1 = (c < 2);
            check("s2 ce", ce, {1'b0, e1, 1'b0});
            check("s2 clk_div", clk_div, {1'b0, c1, 1'b0});
        end

        // 3: program ch0=3, ch2=6 while idle, then realign with sync
        en = 3'b000;
        wr(2'd0, 8'd3, 8'd1);
        step();
        check("s3 pend0", pending, 3'b001);
        wr(2'd2, 8'd6, 8'd3);
        step();
        check("s3 pend2", pending, 3'b100);
        cfg_wr = 1'b0;
        step();
        check("s3 pend idle", pending, 3'b000);
        en = 3'b101;
        for (int k = 0; k < 5; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("s3 sync ce", ce, 3'b000);
        check("s3 sync clk", clk_div, 3'b101);
        for (int k = 1; k <= 20; k++) begin
            // 4: rejected writes interleaved with the running channels
            if (k == 13) wr(2'd0, 8'd0, 8'd0);
            if (k == 14) wr(2'd3, 8'd7, 8'd0);
            if (k == 15) cfg_wr = 1'b0;
            step();
            e0 = (k % 3 == 2);
            e2 = (k % 6 == 5);
            c0 = (k % 3 < 1);
            c1 = (k % 6 < 3);
            check("s3 ce", ce, {e2, 1'b0, e0});
            check("s3 clk_div", clk_div, {c1, 1'b0, c0});
            if (k == 13 || k == 14) begin
                check("s4 cfg_err", cfg_err, 1'b1);
                check("s4 pending", pending, 3'b000);
            end
            if (k == 15) check("s4 cfg_err clr", cfg_err, 1'b0);
        end

        // 5: asynchronous reset while ce[0] and clk_div[2] are high
        #2 areset_n = 1'b0;
        #1;
        check("s5 ce", ce, 3'b000);
        check("s5 clk_div", clk_div, 3'b000);
        check("s5 pending", pending, 3'b000);
        check("s5 cfg_err", cfg_err, 1'b0);
        en = 3'b001;
        #3 areset_n = 1'b1;
        run_s1("s5");

        // 6: ch1 div=1 boundary, ch2 div=8 with high=1
        en = 3'b000;
        wr(2'd1, 8'd1, 8'd0);
        step();
        check("s6 pend1", pending, 3'b010);
        wr(2'd2, 8'd8, 8'd1);
        step();
        check("s6 pend2", pending, 3'b100);
        cfg_wr = 1'b0;
        step();
        check("s6 pend idle", pending, 3'b000);
        en = 3'b110;
        for (int k = 1; k <= 16; k++) begin
            step();
            c  = (k - 1) % 8;
            e2 = (c == 7);
`ifdef CLKDIV_DUTY_EN
            c1 = (c < 1);
`else
            c1 = (c < 4);
`endif
            check("s6 ce", ce, {e2, 1'b1, 1'b0});
            check("s6 clk_div", clk_div, {c1, 2'b00});
        end
        wr(2'd2, 8'd8, 8'd8);
        step();
        cfg_wr = 1'b0;
`ifdef CLKDIV_DUTY_EN
        check("s6 high err", cfg_err, 1'b1);
        check("s6 high pend", pending, 3'b000);
`else
        check("s6 high ignored err", cfg_err, 1'b0);
        check("s6 high ignored pend", pending, 3'b100);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Parametrised multi-channel clock-enable and divided-clock generator, the successor to the fixed divider/inverter in Generators. Each channel has a runtime-programmable divide ratio with shadowed, glitch-free reconfiguration, a per-channel enable, and a global resynchronisation strobe. Outputs feed downstream timing logic as single-cycle enables (ce) and as registered divided-clock waveforms (clk_div).

Parameters:
N_CH, 4, number of independent divider channels (>=1)
CNT_W, 8, counter and divide-ratio width in bits
DIV_INIT, 4, divide ratio loaded into every channel at reset (1..2^CNT_W-1)

Ports:
inclk0  input  1  system clock, all logic on rising edge
areset_n  input  1  asynchronous active-low reset
en  input  N_CH  per-channel run enable
sync  input  1  single-cycle strobe: realign all channel counters
cfg_wr  input  1  configuration write strobe
cfg_ch  input  max(1,$clog2(N_CH))  target channel of write
cfg_div  input  CNT_W  new divide ratio
cfg_high  input  CNT_W  new high time, used only with CLKDIV_DUTY_EN
cfg_err  output  1  one-cycle pulse: write rejected
pending  output  N_CH  shadow ratio waiting to be applied
ce  output  N_CH  one-cycle enable per divided period
clk_div  output  N_CH  registered divided-clock waveform

Behaviour:
- Reset (async assert, sync deassert use): cnt=0, div_act=DIV_INIT, high_act=DIV_INIT/2, pending=0, ce=0, clk_div=0, cfg_err=0. Outputs go to 0 immediately on areset_n low, including mid-period.
- Per channel i: cnt counts 0..div_act-1 while en[i]=1, then wraps to 0.
- ce[i], clk_div[i] are flops updated on the same edge as cnt; ce[i]=1 exactly while cnt==div_act-1 and en[i]=1; clk_div[i]=1 while cnt<high_act and en[i]=1. No combinational output paths.
- Without duty macro, high_act=floor(div_act/2). div=1: ce constantly 1, clk_div constantly 0. div=2: ce every 2nd cycle, clk_div 10 pattern.
- en[i] low: cnt held 0, ce/clk_div 0. en[i] high sampled at edge E0: cnt=0 after E0, first ce after edge E0+div_act-1.
- Config write: cfg_wr=1 with valid data loads div_pend[cfg_ch] and sets pending[cfg_ch] next cycle. Write to a channel with pending=1 overwrites the shadow value (last write wins).
- Shadow apply: on the wrap edge (cnt==div_act-1 -> 0), or on the next edge if en[i]=0, or on sync. pending clears on the same edge. The current period always completes with the old ratio, so no runt pulses.
- Rejected writes (no state change, cfg_err=1 for one cycle): cfg_div==0; cfg_ch>=N_CH. With the macro, also cfg_high>=cfg_div.
- sync=1: every channel cnt<=0 and pending values are applied. ce is forced 0 on that edge. clk_div restarts its high phase. sync coinciding with a wrap: sync wins, no ce that cycle. sync coinciding with cfg_wr: the write goes to shadow and applies at the next wrap.
- Simultaneous cfg_wr and wrap on the same channel: the old shadow (if any) applies now, and the new write becomes pending.

Optional Feature:
CLKDIV_DUTY_EN. Defined: cfg_high is written into a per-channel high_pend shadow alongside div_pend and applied atomically with it. high_act is programmable from 0 to div-1, where 0 gives clk_div constantly 0. Reset high_act=DIV_INIT/2. Undefined: cfg_high is ignored, no high shadow flops exist, and high_act=floor(div_act/2).

Test Plan:
1. Reset release, en=0001, no writes -> ce[0] high every 4th cycle (first after 4th edge); clk_div[0] follows 1100 repeating; other channels 0.
2. en=0010, write ch1 div=5 at cnt=1 -> pending[1]=1 until the current 4-cycle period wraps; then 5-cycle periods, clk_div[1]=11000; pending clears on the wrap edge.
3. ch0 div=3, ch2 div=6 both running; pulse sync at arbitrary time -> both cnt=0, no ce on the sync edge; thereafter ce[0] and ce[2] coincide every 6 cycles.
4. cfg_wr with cfg_div=0, then cfg_ch=N_CH -> cfg_err pulses 1 cycle each; div_act and pending unchanged.
5. areset_n low mid-period with ce/clk_div high -> all outputs 0 without a clock edge; after release, behaviour matches scenario 1.
6. CLKDIV_DUTY_EN: write ch3 div=8 high=1 -> clk_div[3]=10000000, ce[3] every 8th cycle; write high=8 -> cfg_err, no change.
